// File: rtl/led_sweep_pkg.sv
// Shared definitions for the LED bounce-sweep checker.
//  - sweep_state_t : checker FSM states
//  - N_LEDS / SEQ_LEN and default thresholds / counter width
//  - next_idx()    : phase step with 13 -> 0 wrap
//  - pos_of_idx()  : lit LED index for a phase index
package led_sweep_pkg;

  localparam int N_LEDS          = 8;
  localparam int SEQ_LEN         = 2 * N_LEDS - 2;
  localparam int LOCK_THRESH_DEF = 4;
  localparam int MISS_THRESH_DEF = 3;
  localparam int CNT_W           = 16;
  localparam int POS_W           = $clog2(N_LEDS);
  localparam int IDX_W           = $clog2(SEQ_LEN);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ALIGN  = 2'd1,
    SYNC   = 2'd2,
    LOCKED = 2'd3
  } sweep_state_t;

  function automatic int next_idx(input int idx);
    return (idx == SEQ_LEN - 1) ? 0 : idx + 1;
  endfunction

  // Phases 0..N_LEDS-1 walk up, the rest walk back down towards LED 1.
  function automatic int pos_of_idx(input int idx);
    return (idx < N_LEDS) ? idx : SEQ_LEN - idx;
  endfunction

endpackage

// File: rtl/led_sweep_checker_if.sv
// Bus between an LED pattern source and the sweep checker.
//  master : drives led_in / led_valid, observes checker status
//  slave  : the checker; samples led_in, reports position, direction,
//           locked, error, error_count, lap_count
interface led_sweep_checker_if;
  import led_sweep_pkg::*;

  logic [N_LEDS-1:0] led_in;
  logic              led_valid;
  logic [POS_W-1:0]  position;
  logic              direction;
  logic              locked;
  logic              error;
  logic [CNT_W-1:0]  error_count;
  logic [CNT_W-1:0]  lap_count;

  modport master (
    output led_in, led_valid,
    input  position, direction, locked, error, error_count, lap_count
  );

  modport slave (
    input  led_in, led_valid,
    output position, direction, locked, error, error_count, lap_count
  );

endinterface

// File: rtl/led_onehot_decode.sv
// Combinational one-hot classifier for the LED bus.
//  led       in  N_LEDS          sampled LED bus
//  is_onehot out 1               exactly one bit set
//  index     out $clog2(N_LEDS)  position of the set bit (valid when is_onehot)
module led_onehot_decode #(
  parameter int N_LEDS = 8
) (
  input  logic [N_LEDS-1:0]         led,
  output logic                      is_onehot,
  output logic [$clog2(N_LEDS)-1:0] index
);

  localparam int POS_W = $clog2(N_LEDS);
  localparam int CW    = $clog2(N_LEDS + 1);

  logic [CW-1:0] ones;

  // Population count plus index of the highest set bit
  always_comb begin
    ones  = {CW{1'b0}};
    index = {POS_W{1'b0}};
    for (int i = 0; i < N_LEDS; i++) begin
      ones  = ones + CW'(led[i]);
      index = led[i] ? POS_W'(i) : index;
    end
    is_onehot = (ones == CW'(1));
  end

endmodule

// File: rtl/led_sweep_checker.sv
// Receive-side checker for the 8-LED bounce pattern.
// Acquires the sweep phase (HUNT -> ALIGN -> SYNC), then flywheels in
// LOCKED, predicting every accepted sample and flagging deviations.
//  clock, reset_n : single clock, async active-low reset
//  bus (slave)    : led_in/led_valid in; position, direction, locked,
//                   error, error_count, lap_count out (all registered)
// Optional build macro LED_SWEEP_STATS_EN: enables error_count (saturating)
// and lap_count (wrapping); otherwise both outputs are tied to zero.
module led_sweep_checker
  import led_sweep_pkg::*;
#(
  parameter int LOCK_THRESH = LOCK_THRESH_DEF,
  parameter int MISS_THRESH = MISS_THRESH_DEF
) (
  input logic                clock,
  input logic                reset_n,
  led_sweep_checker_if.slave bus
);

  localparam int MC_W = $clog2(LOCK_THRESH + 1);
  localparam int MS_W = $clog2(MISS_THRESH + 1);

  sweep_state_t     state, n_state, h_state;
  logic [IDX_W-1:0] idx, n_idx, h_idx, step_idx;
  logic [POS_W-1:0] p, n_p, h_p;
  logic [MC_W-1:0]  match_cnt, n_match;
  logic [MS_W-1:0]  miss_cnt, n_miss;
  logic             n_err;
  logic             is_onehot;
  logic [POS_W-1:0] led_pos;
  logic             match;
  logic [POS_W-1:0] position_reg;
  logic             direction_reg;
  logic             locked_reg;
  logic             error_reg;

  led_onehot_decode #(.N_LEDS(N_LEDS)) u_decode (
    .led       (bus.led_in),
    .is_onehot (is_onehot),
    .index     (led_pos)
  );

  // Prediction: the sample must be the one-hot image of the next phase
  always_comb begin
    step_idx = IDX_W'(next_idx(int'(idx)));
    match    = is_onehot && (int'(led_pos) == pos_of_idx(int'(step_idx)));
  end

  // Acquisition rules from a single sample; the two ends pin the phase directly
  always_comb begin
    h_state = HUNT;
    h_idx   = idx;
    h_p     = p;
    if (is_onehot) begin
      if (led_pos == {POS_W{1'b0}}) begin
        h_state = SYNC;
        h_idx   = {IDX_W{1'b0}};
      end else if (int'(led_pos) == N_LEDS - 1) begin
        h_state = SYNC;
        h_idx   = IDX_W'(N_LEDS - 1);
      end else begin
        h_state = ALIGN;
        h_p     = led_pos;
      end
    end else begin
      h_state = HUNT;
    end
  end

  // Next-state logic; an idle cycle (led_valid=0) leaves everything as is
  always_comb begin
    n_state = state;
    n_idx   = idx;
    n_p     = p;
    n_match = match_cnt;
    n_miss  = miss_cnt;
    n_err   = 1'b0;
    if (bus.led_valid) begin
      case (state)
        HUNT: begin
          n_state = h_state;
          n_idx   = h_idx;
          n_p     = h_p;
          n_match = {MC_W{1'b0}};
        end
        ALIGN: begin
          n_match = {MC_W{1'b0}};
          if (is_onehot && (int'(led_pos) == int'(p) + 1)) begin
            n_state = SYNC;
            n_idx   = IDX_W'(led_pos);
          end else if (is_onehot && (int'(led_pos) == int'(p) - 1)) begin
            // Falling neighbour: we are on the down stroke
            n_state = SYNC;
            n_idx   = (led_pos == {POS_W{1'b0}}) ? {IDX_W{1'b0}}
                                                 : IDX_W'(SEQ_LEN - int'(led_pos));
          end else begin
            n_state = h_state;
            n_idx   = h_idx;
            n_p     = h_p;
          end
        end
        SYNC: begin
          if (match) begin
            n_idx = step_idx;
            if (int'(match_cnt) + 1 >= LOCK_THRESH) begin
              n_state = LOCKED;
              n_match = {MC_W{1'b0}};
              n_miss  = {MS_W{1'b0}};
            end else begin
              n_match = match_cnt + MC_W'(1);
            end
          end else begin
            n_state = h_state;
            n_idx   = h_idx;
            n_p     = h_p;
            n_match = {MC_W{1'b0}};
          end
        end
        LOCKED: begin
          // Flywheel: the phase advances whether or not the sample matched
          n_idx = step_idx;
          if (match) begin
            n_miss = {MS_W{1'b0}};
          end else begin
            n_err = 1'b1;
            if (int'(miss_cnt) + 1 >= MISS_THRESH) begin
              n_state = HUNT;
              n_miss  = {MS_W{1'b0}};
            end else begin
              n_miss = miss_cnt + MS_W'(1);
            end
          end
        end
        default: begin
          n_state = HUNT;
          n_idx   = {IDX_W{1'b0}};
          n_match = {MC_W{1'b0}};
          n_miss  = {MS_W{1'b0}};
        end
      endcase
    end else begin
      n_err = 1'b0;
    end
  end

  // FSM state and registered status outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= HUNT;
      idx           <= {IDX_W{1'b0}};
      p             <= {POS_W{1'b0}};
      match_cnt     <= {MC_W{1'b0}};
      miss_cnt      <= {MS_W{1'b0}};
      position_reg  <= {POS_W{1'b0}};
      direction_reg <= 1'b0;
      locked_reg    <= 1'b0;
      error_reg     <= 1'b0;
    end else begin
      error_reg <= n_err;
      if (bus.led_valid) begin
        state      <= n_state;
        idx        <= n_idx;
        p          <= n_p;
        match_cnt  <= n_match;
        miss_cnt   <= n_miss;
        locked_reg <= (n_state == LOCKED);
        // Position/direction hold their last value while acquiring
        if (n_state == SYNC || n_state == LOCKED) begin
          position_reg  <= POS_W'(pos_of_idx(int'(n_idx)));
          direction_reg <= (int'(n_idx) >= N_LEDS - 1);
        end
      end
    end
  end

  assign bus.position  = position_reg;
  assign bus.direction = direction_reg;
  assign bus.locked    = locked_reg;
  assign bus.error     = error_reg;

`ifdef LED_SWEEP_STATS_EN
  logic [CNT_W-1:0] error_count_reg;
  logic [CNT_W-1:0] lap_count_reg;
  logic             lap_hit;

  // A lap completes on a matched locked sample that lands on phase 0
  assign lap_hit = bus.led_valid && (state == LOCKED) && match &&
                   (step_idx == {IDX_W{1'b0}});

  // Statistics counters: errors saturate, laps wrap
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      error_count_reg <= {CNT_W{1'b0}};
      lap_count_reg   <= {CNT_W{1'b0}};
    end else begin
      if (n_err && (error_count_reg != {CNT_W{1'b1}})) begin
        error_count_reg <= error_count_reg + CNT_W'(1);
      end
      if (lap_hit) begin
        lap_count_reg <= lap_count_reg + CNT_W'(1);
      end
    end
  end

  assign bus.error_count = error_count_reg;
  assign bus.lap_count   = lap_count_reg;
`else
  assign bus.error_count = {CNT_W{1'b0}};
  assign bus.lap_count   = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_led_sweep_checker.sv
// Self-checking bench for led_sweep_checker: directed scenarios plus a
// randomized run, all compared against a phase-table reference model.
module tb_led_sweep_checker;
  import led_sweep_pkg::*;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  led_sweep_checker_if bus ();

  led_sweep_checker dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  localparam int M_HUNT = 0, M_ALIGN = 1, M_SYNC = 2, M_LOCKED = 3;

  // Lit LED for each phase of the bounce, built by walking the LED back and forth
  int phase_pos [14];
  int m_state, m_idx, m_p, m_match, m_miss, m_pos, m_dir, m_locked, m_err, m_ecnt, m_lap;
  int src;

  function automatic logic [7:0] led_of_phase(input int k);
    logic [7:0] one;
    one = 8'd1;
    return one << phase_pos[k];
  endfunction

  function automatic logic [5:0] status_exp();
    logic [2:0] pos3;
    pos3 = 3'(m_pos);
    return {m_locked[0], m_err[0], m_dir[0], pos3};
  endfunction

  function automatic logic [15:0] exp_ecnt();
`ifdef LED_SWEEP_STATS_EN
    return 16'(m_ecnt);
`else
    return 16'd0;
`endif
  endfunction

  function automatic logic [15:0] exp_lap();
`ifdef LED_SWEEP_STATS_EN
    return 16'(m_lap);
`else
    return 16'd0;
`endif
  endfunction

  task automatic build_table();
    int p, d;
    p = 0; d = 1;
    for (int k = 0; k < 14; k++) begin
      phase_pos[k] = p;
      if (p == 7) d = -1;
      p = p + d;
    end
  endtask

  task automatic model_reset();
    m_state = M_HUNT; m_idx = 0; m_p = 0; m_match = 0; m_miss = 0;
    m_pos = 0; m_dir = 0; m_locked = 0; m_err = 0; m_ecnt = 0; m_lap = 0;
  endtask

  task automatic model_enter_sync(input int i);
    m_state = M_SYNC; m_idx = i; m_match = 0;
  endtask

  task automatic model_hunt(input int q);
    if (q == 0) model_enter_sync(0);
    else if (q == 7) model_enter_sync(7);
    else if (q > 0) begin m_state = M_ALIGN; m_p = q; end
    else m_state = M_HUNT;
  endtask

  task automatic model_step(input logic [7:0] led, input bit v);
    int q;
    bit hit;
    m_err = 0;
    if (v) begin
      q = -1;
      if ($countones(led) == 1) begin
        for (int b = 0; b < 8; b++) if (led[b]) q = b;
      end
      hit = (led == led_of_phase((m_idx + 1) % 14));
      case (m_state)
        M_HUNT: model_hunt(q);
        M_ALIGN: begin
          if (q >= 0 && q == m_p + 1) model_enter_sync(q);
          else if (q >= 0 && q == m_p - 1) model_enter_sync(q == 0 ? 0 : 14 - q);
          else model_hunt(q);
        end
        M_SYNC: begin
          if (hit) begin
            m_idx = (m_idx + 1) % 14;
            m_match++;
            if (m_match == 4) begin m_state = M_LOCKED; m_miss = 0; end
          end else begin
            m_match = 0;
            model_hunt(q);
          end
        end
        default: begin
          m_idx = (m_idx + 1) % 14;
          if (hit) begin
            m_miss = 0;
            if (m_idx == 0) m_lap = (m_lap + 1) % 65536;
          end else begin
            m_err = 1;
            if (m_ecnt < 65535) m_ecnt++;
            m_miss++;
            if (m_miss == 3) m_state = M_HUNT;
          end
        end
      endcase
      m_locked = (m_state == M_LOCKED);
      if (m_state == M_SYNC || m_state == M_LOCKED) begin
        m_pos = phase_pos[m_idx];
        m_dir = (m_idx >= 7);
      end
    end
  endtask

  task automatic drive(input logic [7:0] led, input bit v);
    bus.led_in = led;
    bus.led_valid = v;
    @(posedge clock);
    model_step(led, v);
    #1;
  endtask

  task automatic feed_clean();
    drive(led_of_phase(src), 1'b1);
    src = (src + 1) % 14;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.led_in = 8'h00;
    bus.led_valid = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({bus.locked, bus.error, bus.direction, bus.position} !== 6'd0) begin
      errors++;
      $display("FAIL reset_status got=%h want=00", {bus.locked, bus.error, bus.direction, bus.position});
    end
    checks++;
    if ({bus.error_count, bus.lap_count} !== 32'd0) begin
      errors++;
      $display("FAIL reset_counters got=%h want=0", {bus.error_count, bus.lap_count});
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_clean_sweep();
    src = 0;
    for (int i = 0; i < 14; i++) begin
      feed_clean();
      checks++;
      if ({bus.locked, bus.error, bus.direction, bus.position} !== status_exp()) begin
        errors++;
        $display("FAIL clean_sweep step=%0d got=%h want=%h", i,
                 {bus.locked, bus.error, bus.direction, bus.position}, status_exp());
      end
      if (i == 3 || i == 4) begin
        checks++;
        if (bus.locked !== (i == 4)) begin
          errors++;
          $display("FAIL lock_point step=%0d got=%b want=%b", i, bus.locked, (i == 4));
        end
      end
    end
  endtask

  task automatic test_single_error();
    src = 0;
    for (int i = 0; i < 11; i++) feed_clean();
    drive(8'h00, 1'b1);
    src = (src + 1) % 14;
    checks++;
    if ({bus.locked, bus.error} !== 2'b11) begin
      errors++;
      $display("FAIL single_error got=%b want=11", {bus.locked, bus.error});
    end
    checks++;
    if (bus.error_count !== exp_ecnt()) begin
      errors++;
      $display("FAIL error_count got=%0d want=%0d", bus.error_count, exp_ecnt());
    end
    feed_clean();
    checks++;
    if ({bus.locked, bus.error, bus.direction, bus.position} !== 6'b101010) begin
      errors++;
      $display("FAIL after_error got=%b want=101010", {bus.locked, bus.error, bus.direction, bus.position});
    end
  endtask

  task automatic test_triple_miss();
    for (int i = 0; i < 3; i++) begin
      drive(8'hFF, 1'b1);
      src = (src + 1) % 14;
      checks++;
      if ({bus.locked, bus.error} !== {(i < 2), 1'b1}) begin
        errors++;
        $display("FAIL triple_miss n=%0d got=%b want=%b", i, {bus.locked, bus.error}, {(i < 2), 1'b1});
      end
    end
    for (int i = 0; i < 8; i++) begin
      feed_clean();
      checks++;
      if ({bus.locked, bus.error, bus.direction, bus.position} !== status_exp()) begin
        errors++;
        $display("FAIL relock step=%0d got=%h want=%h", i,
                 {bus.locked, bus.error, bus.direction, bus.position}, status_exp());
      end
    end
    checks++;
    if (bus.locked !== 1'b1) begin
      errors++;
      $display("FAIL relocked got=%b want=1", bus.locked);
    end
  endtask

  task automatic test_laps();
    for (int i = 0; i < 28; i++) feed_clean();
    checks++;
    if ({bus.error_count, bus.lap_count} !== {exp_ecnt(), exp_lap()}) begin
      errors++;
      $display("FAIL laps got=%0d/%0d want=%0d/%0d", bus.error_count, bus.lap_count, exp_ecnt(), exp_lap());
    end
  endtask

  task automatic test_valid_gap();
    for (int i = 0; i < 5; i++) begin
      drive(8'($urandom), 1'b0);
      checks++;
      if ({bus.locked, bus.error, bus.direction, bus.position} !== status_exp()) begin
        errors++;
        $display("FAIL valid_gap cycle=%0d got=%h want=%h", i,
                 {bus.locked, bus.error, bus.direction, bus.position}, status_exp());
      end
    end
  endtask

  task automatic test_mid_sweep();
    @(negedge clock);
    reset_n = 1'b0;
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    src = 9;
    feed_clean();
    feed_clean();
    checks++;
    if ({bus.locked, bus.direction, bus.position} !== 5'b01100) begin
      errors++;
      $display("FAIL mid_align got=%b want=01100", {bus.locked, bus.direction, bus.position});
    end
    for (int i = 0; i < 4; i++) feed_clean();
    checks++;
    if ({bus.locked, bus.direction, bus.position} !== 5'b10000) begin
      errors++;
      $display("FAIL mid_lock got=%b want=10000", {bus.locked, bus.direction, bus.position});
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60) feed_clean();
      else if (r < 70) drive(8'($urandom), 1'b0);
      else if (r < 80) drive(8'($urandom), 1'b1);
      else if (r < 90) drive(8'd1 << $urandom_range(0, 7), 1'b1);
      else begin
        src = $urandom_range(0, 13);
        feed_clean();
      end
      checks++;
      if ({bus.locked, bus.error, bus.direction, bus.position} !== status_exp() ||
          {bus.error_count, bus.lap_count} !== {exp_ecnt(), exp_lap()}) begin
        errors++;
        $display("FAIL random cycle=%0d got=%h/%0d/%0d want=%h/%0d/%0d", i,
                 {bus.locked, bus.error, bus.direction, bus.position}, bus.error_count, bus.lap_count,
                 status_exp(), exp_ecnt(), exp_lap());
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 14; i++) feed_clean();
    checks++;
    if (bus.locked !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_lock got=%b want=1", bus.locked);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.locked, bus.error, bus.direction, bus.position, bus.error_count, bus.lap_count} !== 38'd0) begin
      errors++;
      $display("FAIL async_reset got=%h want=0",
               {bus.locked, bus.error, bus.direction, bus.position, bus.error_count, bus.lap_count});
    end
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    build_table();
    test_reset();
    test_clean_sweep();
    test_single_error();
    test_triple_miss();
    test_laps();
    test_valid_gap();
    test_mid_sweep();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
